// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID fetch queue.
// Entries pair a fetched instruction with its PC+2.
package if_id_pkg;

  localparam int unsigned INSTR_W_DEF = 16;
  localparam int unsigned PC_W_DEF    = 16;

  localparam logic [INSTR_W_DEF-1:0] NOP_VAL_DEF = 16'hFFFF;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pcplus2;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = INSTR_W_DEF + PC_W_DEF;

  // Wrapping increment for pointers into a non-power-of-two ring.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// Circular storage for the fetch queue: array, wrapping pointers and occupancy count.
// Reads are combinational from the head entry; clear resets pointers and count.
module if_id_queue_mem
  import if_id_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = FETCH_ENTRY_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = PTR_W'(wrap_inc(int'(wr_ptr_q), DEPTH));
      if (rd_en) rd_ptr_d = PTR_W'(wrap_inc(int'(rd_ptr_q), DEPTH));
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; contents are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: DEPTH-entry FIFO behind a registered output stage, with
// single-cycle bypass when empty, flush, stall, and NOP bubbles on the output.
module if_id_fetch_queue
  import if_id_pkg::*;
#(
  parameter int unsigned         INSTR_W = INSTR_W_DEF,
  parameter int unsigned         PC_W    = PC_W_DEF,
  parameter int unsigned         DEPTH   = 4,
  parameter logic [INSTR_W-1:0]  NOP_VAL = {INSTR_W{1'b1}},
  localparam int unsigned        OCC_W   = $clog2(DEPTH + 2)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pcplus2_in,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pcplus2_out,
  output logic [OCC_W-1:0]   occupancy
);

  localparam int unsigned DATA_W = INSTR_W + PC_W;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pcplus2;
  } entry_t;

  localparam entry_t NopEntry = '{instr: NOP_VAL, pcplus2: '0};

  entry_t            in_entry, head_entry;
  entry_t            out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;
  logic              full, empty;
  logic              push, consume, load, pop, bypass, wr_en;

  assign in_entry   = '{instr: instr_in, pcplus2: pcplus2_in};
  assign head_entry = entry_t'(rd_data);

  // in_ready depends only on registered count, never on stall or flush.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign consume  = out_valid_q && !stall;
  assign load     = !out_valid_q || consume;
  assign pop      = !flush && load && !empty;
  assign bypass   = !flush && load && empty && push;
  assign wr_en    = !flush && push && !bypass;

  if_id_queue_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .wr_en   (wr_en),
    .rd_en   (pop),
    .wr_data (in_entry),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_d       = NopEntry;
    end else if (load) begin
      if (!empty) begin
        out_valid_d = 1'b1;
        out_d       = head_entry;
      end else if (push) begin
        out_valid_d = 1'b1;
        out_d       = in_entry;
      end else begin
        out_valid_d = 1'b0;
        out_d       = NopEntry;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_q       <= NopEntry;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign instr_out   = out_q.instr;
  assign pcplus2_out = out_q.pcplus2;
  assign occupancy   = OCC_W'(count) + OCC_W'(out_valid_q);

endmodule
